// File: rtl/ex_wb_stage_pkg.sv
// Shared types and codes for the EX->WB stage: writeback selects, load funct3 codes
// and the buffered entry layout.
package ex_wb_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_PC4 = 2'd1;
  localparam logic [1:0] WB_SEL_MEM = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic               valid;
    logic               pending;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic [1:0]         wb_sel;
    logic [2:0]         funct3;
    logic [1:0]         off;
    logic [XLEN-1:0]    result;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] select_result(input logic [1:0]      wb_sel,
                                                   input logic [XLEN-1:0] alu,
                                                   input logic [XLEN-1:0] pc4);
    return (wb_sel == WB_SEL_PC4) ? pc4 : alu;
  endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// EX->WB stage bus: EX offer handshake, dmem read return and the writeback bus.
// master = surrounding pipeline, slave = the stage.
interface ex_wb_stage_if;
  import ex_wb_stage_pkg::*;

  logic               ex_valid;
  logic               ex_ready;
  logic               ex_flush;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_reg_we;
  logic [1:0]         ex_wb_sel;
  logic [2:0]         ex_funct3;
  logic [XLEN-1:0]    ex_alu_result;
  logic [XLEN-1:0]    ex_pc_plus4;
  logic               dmem_rvalid;
  logic [XLEN-1:0]    dmem_rdata;
  logic               wb_ready;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_addr;
  logic               is_wb;
  logic [XLEN-1:0]    wb_data;

  modport master (
    output ex_valid, ex_flush, ex_rd, ex_reg_we, ex_wb_sel, ex_funct3,
           ex_alu_result, ex_pc_plus4, dmem_rvalid, dmem_rdata, wb_ready,
    input  ex_ready, wb_valid, wb_addr, is_wb, wb_data
  );

  modport slave (
    input  ex_valid, ex_flush, ex_rd, ex_reg_we, ex_wb_sel, ex_funct3,
           ex_alu_result, ex_pc_plus4, dmem_rvalid, dmem_rdata, wb_ready,
    output ex_ready, wb_valid, wb_addr, is_wb, wb_data
  );

endinterface

// File: rtl/ex_wb_stage_load_align.sv
// load_align: extracts the byte/halfword selected by the load offset and extends it
// to XLEN; word loads pass through as read.
module load_align
  import ex_wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{off, 3'b000} +: 8];
  assign half_s = rdata[{off[1], 4'b0000} +: 16];

  // size/sign selection
  always_comb begin
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline stage: buffers retiring EX results, merges dmem load data and drives
// the writeback bus. EX_WB_SKID_EN adds a skid entry and registers ex_ready.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  ex_wb_stage_if.slave bus
);

  // Slot 0 is the head (oldest); slot 1 is the skid slot, never filled in the 1-entry build.
  wb_entry_t       entry_r  [2];
  wb_entry_t       filled_s [2];
  wb_entry_t       popped_s [2];
  wb_entry_t       entry_s  [2];
  wb_entry_t       incoming_s;
  logic            head_valid_s;
  logic            pop_s;
  logic            accept_s;
  logic            ready_s;
  logic            fill_en_s;
  logic            fill_idx_s;
  logic [2:0]      fill_funct3_s;
  logic [1:0]      fill_off_s;
  logic [XLEN-1:0] aligned_s;

  assign head_valid_s = entry_r[0].valid & ~entry_r[0].pending;
  assign pop_s        = head_valid_s & bus.wb_ready;
  assign accept_s     = bus.ex_valid & ready_s & ~bus.ex_flush;

  // Returned load data belongs to the oldest pending entry.
  assign fill_idx_s    = ~(entry_r[0].valid & entry_r[0].pending);
  assign fill_en_s     = bus.dmem_rvalid & entry_r[fill_idx_s].valid & entry_r[fill_idx_s].pending;
  assign fill_funct3_s = entry_r[fill_idx_s].funct3;
  assign fill_off_s    = entry_r[fill_idx_s].off;

  load_align u_load_align (
    .funct3 (fill_funct3_s),
    .off    (fill_off_s),
    .rdata  (bus.dmem_rdata),
    .data   (aligned_s)
  );

  // build the entry offered by EX
  always_comb begin
    incoming_s         = '0;
    incoming_s.valid   = 1'b1;
    incoming_s.pending = (bus.ex_wb_sel == WB_SEL_MEM);
    incoming_s.rd      = bus.ex_rd;
    incoming_s.we      = bus.ex_reg_we;
    incoming_s.wb_sel  = bus.ex_wb_sel;
    incoming_s.funct3  = bus.ex_funct3;
    incoming_s.off     = bus.ex_alu_result[1:0];
    incoming_s.result  = select_result(bus.ex_wb_sel, bus.ex_alu_result, bus.ex_pc_plus4);
  end

  // next buffer state: fill, then pop, then append at the first free slot
  always_comb begin
    filled_s                     = entry_r;
    filled_s[fill_idx_s].pending = entry_r[fill_idx_s].pending & ~fill_en_s;
    filled_s[fill_idx_s].result  = fill_en_s ? aligned_s : entry_r[fill_idx_s].result;

    popped_s[0] = pop_s ? filled_s[1] : filled_s[0];
    popped_s[1] = pop_s ? wb_entry_t'('0) : filled_s[1];

    entry_s = popped_s;
    if (accept_s && !popped_s[0].valid) begin
      entry_s[0] = incoming_s;
    end else if (accept_s) begin
      entry_s[1] = incoming_s;
    end else begin
      entry_s[0] = popped_s[0];
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_r[0] <= '0;
      entry_r[1] <= '0;
    end else begin
      entry_r <= entry_s;
    end
  end

`ifdef EX_WB_SKID_EN
  logic ex_ready_r;

  // ex_ready follows next-cycle skid occupancy, so no path from wb_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ready_r <= 1'b1;
    end else begin
      ex_ready_r <= ~entry_s[1].valid;
    end
  end

  assign ready_s = ex_ready_r;
`else
  assign ready_s = ~entry_r[0].valid | pop_s;
`endif

  assign bus.ex_ready = ready_s;
  assign bus.wb_valid = head_valid_s;
  assign bus.wb_addr  = entry_r[0].rd;
  assign bus.is_wb    = head_valid_s & entry_r[0].we & (entry_r[0].rd != {RADDR_W{1'b0}});
  assign bus.wb_data  = entry_r[0].result;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed cases plus random traffic compared
// against a queue-based reference model of the stage.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

`ifdef EX_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        pending;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
  } rec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  rec_t q[$];
  logic [1:0] sel_tab [3];
  logic [2:0] f3_tab  [5];

  ex_wb_stage_if bus ();

  ex_wb_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    int b;
    int h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * off[1])) & 32'hFFFF);
    case (f3)
      3'b000:  return 32'((b >= 128) ? b - 256 : b);
      3'b100:  return 32'(b);
      3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic offer(input logic v, input logic fl, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4);
    bus.ex_valid      = v;
    bus.ex_flush      = fl;
    bus.ex_rd         = rd;
    bus.ex_reg_we     = we;
    bus.ex_wb_sel     = sel;
    bus.ex_funct3     = f3;
    bus.ex_alu_result = alu;
    bus.ex_pc_plus4   = pc4;
  endtask

  task automatic idle();
    offer(1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU, 3'b000, 32'd0, 32'd0);
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic tick();
    logic exp_valid;
    logic exp_ready;
    logic exp_iswb;
    logic acc;
    logic filled;
    rec_t r;
    #1;
    exp_valid = (q.size() > 0) ? !q[0].pending : 1'b0;
    exp_iswb  = exp_valid ? (q[0].we && q[0].rd != 5'd0) : 1'b0;
    exp_ready = SKID ? (q.size() < 2) : ((q.size() == 0) || (exp_valid && bus.wb_ready));
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, exp_valid});
    check("ex_ready", {31'd0, bus.ex_ready}, {31'd0, exp_ready});
    check("is_wb", {31'd0, bus.is_wb}, {31'd0, exp_iswb});
    if (exp_valid) begin
      check("wb_addr", {27'd0, bus.wb_addr}, {27'd0, q[0].rd});
      check("wb_data", bus.wb_data, q[0].data);
    end
    acc    = bus.ex_valid && exp_ready && !bus.ex_flush;
    filled = 1'b0;
    if (bus.dmem_rvalid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!filled && q[i].pending) begin
          r         = q[i];
          r.pending = 1'b0;
          r.data    = ref_align(r.f3, r.off, bus.dmem_rdata);
          q[i]      = r;
          filled    = 1'b1;
        end
      end
    end
    if (exp_valid && bus.wb_ready) void'(q.pop_front());
    if (acc) begin
      r.rd      = bus.ex_rd;
      r.we      = bus.ex_reg_we;
      r.pending = (bus.ex_wb_sel == WB_SEL_MEM);
      r.f3      = bus.ex_funct3;
      r.off     = bus.ex_alu_result[1:0];
      r.data    = (bus.ex_wb_sel == WB_SEL_PC4) ? bus.ex_pc_plus4 : bus.ex_alu_result;
      q.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] exp);
    offer(1'b1, 1'b0, 5'd7, 1'b1, WB_SEL_MEM, f3, 32'h0000_1002, 32'h0);
    tick();
    idle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h80FF_0000;
    #1 check({tag, "_pending"}, {31'd0, bus.wb_valid}, 32'd0);
    tick();
    idle();
    #1 check(tag, bus.wb_data, exp);
    tick();
  endtask

  initial begin
    int has_pend;
    errors     = 0;
    checks     = 0;
    sel_tab[0] = WB_SEL_ALU;
    sel_tab[1] = WB_SEL_PC4;
    sel_tab[2] = WB_SEL_MEM;
    f3_tab[0]  = F3_LB;
    f3_tab[1]  = F3_LH;
    f3_tab[2]  = F3_LW;
    f3_tab[3]  = F3_LBU;
    f3_tab[4]  = F3_LHU;
    rst_n = 1'b0;
    idle();
    bus.wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_is_wb", {31'd0, bus.is_wb}, 32'd0);
    check("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);

    // 1: ALU op visible one cycle after accept
    offer(1'b1, 1'b0, 5'd5, 1'b1, WB_SEL_ALU, 3'b000, 32'h0000_1234, 32'h0);
    tick();
    idle();
    #1;
    check("alu_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("alu_addr", {27'd0, bus.wb_addr}, 32'd5);
    check("alu_is_wb", {31'd0, bus.is_wb}, 32'd1);
    check("alu_data", bus.wb_data, 32'h0000_1234);
    tick();

    // 2: load alignment
    load_case("lb", F3_LB, 32'hFFFF_FFFF);
    load_case("lbu", F3_LBU, 32'h0000_00FF);
    load_case("lh", F3_LH, 32'hFFFF_80FF);

    // 3: rd == 0 flows but does not write
    offer(1'b1, 1'b0, 5'd0, 1'b1, WB_SEL_ALU, 3'b000, 32'h0000_DEAD, 32'h0);
    tick();
    idle();
    #1;
    check("rd0_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("rd0_is_wb", {31'd0, bus.is_wb}, 32'd0);
    check("rd0_data", bus.wb_data, 32'h0000_DEAD);
    tick();

    // 4: back-to-back ops under backpressure
    bus.wb_ready = 1'b0;
    offer(1'b1, 1'b0, 5'd1, 1'b1, WB_SEL_ALU, 3'b000, 32'hA1, 32'h0);
    tick();
    offer(1'b1, 1'b0, 5'd2, 1'b1, WB_SEL_PC4, 3'b000, 32'hA2, 32'hB2);
    #1 check("bp_ready_1", {31'd0, bus.ex_ready}, {31'd0, SKID});
    tick();
    offer(1'b1, 1'b0, 5'd3, 1'b1, WB_SEL_ALU, 3'b000, 32'hA3, 32'h0);
    #1 check("bp_ready_2", {31'd0, bus.ex_ready}, 32'd0);
    tick();
    tick();
    idle();
    bus.wb_ready = 1'b1;
    repeat (4) tick();

    // 5: flushed offer leaves nothing behind
    offer(1'b1, 1'b1, 5'd9, 1'b1, WB_SEL_ALU, 3'b000, 32'h77, 32'h0);
    tick();
    idle();
    #1;
    check("flush_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("flush_ready", {31'd0, bus.ex_ready}, 32'd1);
    tick();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      has_pend = 0;
      foreach (q[i]) if (q[i].pending) has_pend = 1;
      offer(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), sel_tab[$urandom_range(0, 2)], f3_tab[$urandom_range(0, 4)],
            $urandom(), $urandom());
      bus.dmem_rvalid = (has_pend != 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      bus.dmem_rdata  = $urandom();
      bus.wb_ready    = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    bus.wb_ready = 1'b1;
    bus.dmem_rvalid = 1'b1;
    repeat (4) tick();
    idle();
    repeat (2) tick();

    // 6: reset while an entry is held and a load is outstanding
    bus.wb_ready = 1'b0;
    offer(1'b1, 1'b0, 5'd9, 1'b1, WB_SEL_ALU, 3'b000, 32'h55, 32'h0);
    tick();
    offer(1'b1, 1'b0, 5'd10, 1'b1, WB_SEL_MEM, F3_LW, 32'h100, 32'h0);
    tick();
    idle();
    #1 check("pre_rst_valid", {31'd0, bus.wb_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("mid_rst_is_wb", {31'd0, bus.is_wb}, 32'd0);
    check("mid_rst_data", bus.wb_data, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.wb_ready    = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    tick();
    idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
